apb_delayer_param: RTL and testbench
====================================

APB_DELAYER_PARAM -- requirements
Module: apb_delayer_param

Interface
REQ-001 Parameter ADDR_W, default 32: APB address width.
REQ-002 Parameter DATA_W, default 32: APB data width; PSTRB width is DATA_W/8.
REQ-003 Parameter WIN_BASE, default 32'ha000_0000: inclusive lower bound of the delayed address window.
REQ-004 Parameter WIN_LIMIT, default 32'hc000_0000: exclusive upper bound of the delayed address window.
REQ-005 Parameter FRAC, default 4: fractional bits of ratio.
REQ-006 Parameter CNT_W, default 16: width of the integer part of the accumulator and of the extra-wait counter.
REQ-007 Ports, one per line:
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- ratio  in  8  unsigned fixed-point delay ratio, FRAC fractional bits; 16 (FRAC=4) is 1.0.
- in_paddr, in_psel, in_penable, in_pprot[3], in_pwrite, in_pwdata, in_pstrb  in  -  upstream APB request.
- in_pready, in_prdata, in_pslverr  out  -  upstream APB response.
- out_paddr, out_psel, out_penable, out_pprot[3], out_pwrite, out_pwdata, out_pstrb  out  -  downstream APB request.
- out_pready, out_prdata, out_pslverr  in  -  downstream APB response.

Function
REQ-008 The address, prot, write, wdata and strb signals SHALL pass combinationally from in_* to out_* in all states.
REQ-009 Hit SHALL be defined as (WIN_BASE <= in_paddr < WIN_LIMIT).
REQ-010 In IDLE, a non-hit access SHALL pass through combinationally: out_psel/out_penable mirror the in_* signals, and in_pready/in_prdata/in_pslverr mirror the out_* signals.
REQ-011 The FSM SHALL have the states IDLE, FWD, WAIT and RESP.
REQ-012 IDLE, on in_psel and hit: out_psel = 1, out_penable = 0, in_pready = 0; latch ratio into ratio_q; clear acc and N; go to FWD.
REQ-013 FWD: out_psel/out_penable mirror the in_* signals; in_pready = 0.
- Each cycle with in_penable high: acc += ratio_q, N += 1; both saturate at all-ones.
REQ-014 FWD, when out_pready = 1 with in_penable = 1: this cycle is counted; latch out_prdata and out_pslverr.
- Load E = max((acc_incl_this_cycle >> FRAC) - N_incl, 0).
- Next state is WAIT if E > 0, else RESP.
REQ-015 WAIT: out_psel = out_penable = 0, in_pready = 0; decrement E each cycle; go to RESP in the cycle E reaches 1.
REQ-016 RESP: in_pready = 1 for exactly one cycle with the latched prdata/pslverr; out_psel = 0; return to IDLE.
REQ-017 Latency: in_pready SHALL assert exactly 1+E cycles after the cycle in which out_pready was sampled high.
REQ-018 Ratios of 1.0 or below SHALL give E = 0: the delay then reduces to a single registered cycle.
REQ-019 ratio = 0 SHALL be legal and SHALL give E = 0.
REQ-020 A change on ratio during FWD/WAIT SHALL NOT affect the current transfer; only ratio_q is used.
REQ-021 If in_psel drops in FWD, WAIT or RESP (protocol violation), the FSM SHALL return to IDLE next cycle, drive in_pready = 0 and discard the latched response.
REQ-022 in_paddr changing mid-transfer SHALL NOT re-evaluate hit until IDLE.
REQ-023 Back-to-back hit accesses SHALL take at least one IDLE cycle between RESP and the next FWD.

Reset
REQ-024 While reset is high: state = IDLE; acc, N, E, ratio_q and the latched prdata/pslverr = 0.
REQ-025 Outputs during reset SHALL follow the IDLE rules; reset asserted mid-transfer SHALL abandon the transfer without asserting in_pready.

Verification
REQ-026 ratio=80 (5.0), hit read, slave ready on 2nd access cycle, prdata=0x1234_5678 -> E=8; in_pready high 9 cycles after the out_pready cycle, in_prdata=0x1234_5678.
REQ-027 ratio=16 (1.0), hit write, zero-wait slave -> E=0; in_pready exactly 1 cycle after out_pready; out_psel low in RESP.
REQ-028 Non-hit access at 0x3000_0000 with ratio=80 -> in_pready == out_pready in the same cycle; FSM stays IDLE.
REQ-029 ratio=24 (1.5), slave takes N=3 -> acc=72, 72>>4=4, E=1; in_pready 2 cycles after out_pready; pslverr=1 propagated.
REQ-030 Reset pulsed during WAIT with E=5 remaining -> no in_pready; next cycle is IDLE; a following hit access completes normally.
REQ-031 ratio changed 80->16 during FWD -> E computed with 80.

Source files
------------

// File: rtl/apb_delayer_param_if.sv
// Upstream and downstream APB signals of the delayer, grouped into one bundle.
// The slave modport is the delayer's view; the master modport is the environment's.
interface apb_delayer_param_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   in_paddr;
  logic                in_psel;
  logic                in_penable;
  logic [2:0]          in_pprot;
  logic                in_pwrite;
  logic [DATA_W-1:0]   in_pwdata;
  logic [DATA_W/8-1:0] in_pstrb;
  logic                in_pready;
  logic [DATA_W-1:0]   in_prdata;
  logic                in_pslverr;

  logic [ADDR_W-1:0]   out_paddr;
  logic                out_psel;
  logic                out_penable;
  logic [2:0]          out_pprot;
  logic                out_pwrite;
  logic [DATA_W-1:0]   out_pwdata;
  logic [DATA_W/8-1:0] out_pstrb;
  logic                out_pready;
  logic [DATA_W-1:0]   out_prdata;
  logic                out_pslverr;

  modport slave (
    input  in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
    output in_pready, in_prdata, in_pslverr,
    output out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb,
    input  out_pready, out_prdata, out_pslverr
  );

  modport master (
    output in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
    input  in_pready, in_prdata, in_pslverr,
    input  out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb,
    output out_pready, out_prdata, out_pslverr
  );
endinterface

// File: rtl/apb_delayer_param.sv
// APB bridge that stretches accesses inside an address window by a fixed-point
// ratio of the slave's own access time; other addresses pass straight through.
module apb_delayer_param #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] WIN_BASE  = ADDR_W'(32'ha000_0000),
  parameter logic [ADDR_W-1:0] WIN_LIMIT = ADDR_W'(32'hc000_0000),
  parameter int                FRAC      = 4,
  parameter int                CNT_W     = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          ratio,
  apb_delayer_param_if.slave  bus
);

  localparam int ACC_W = CNT_W + FRAC;

  typedef enum logic [1:0] {IDLE, FWD, WAIT, RESP} state_t;

  state_t              state_q, state_d, cur_state;
  logic [7:0]          ratio_q, ratio_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_inc;
  logic [CNT_W-1:0]    n_q, n_d, n_inc;
  logic [CNT_W-1:0]    e_q, e_d, e_new, acc_int;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [ACC_W:0]      acc_sum;
  logic [CNT_W:0]      n_sum;
  logic                hit;

  assign bus.out_paddr  = bus.in_paddr;
  assign bus.out_pprot  = bus.in_pprot;
  assign bus.out_pwrite = bus.in_pwrite;
  assign bus.out_pwdata = bus.in_pwdata;
  assign bus.out_pstrb  = bus.in_pstrb;

  assign hit = (bus.in_paddr >= WIN_BASE) && (bus.in_paddr < WIN_LIMIT);

  // Outputs decode as IDLE while reset is held, so a transfer cut by reset never completes.
  assign cur_state = reset ? IDLE : state_q;

  always_comb begin
    acc_sum = {1'b0, acc_q} + (ACC_W+1)'(ratio_q);
    acc_inc = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    n_sum   = {1'b0, n_q} + (CNT_W+1)'(1);
    n_inc   = n_sum[CNT_W] ? '1 : n_sum[CNT_W-1:0];
    acc_int = acc_inc[ACC_W-1:FRAC];
    e_new   = (acc_int > n_inc) ? (acc_int - n_inc) : '0;
  end

  always_comb begin
    state_d = state_q;
    ratio_d = ratio_q;
    acc_d   = acc_q;
    n_d     = n_q;
    e_d     = e_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_psel && hit) begin
          ratio_d = ratio;
          acc_d   = '0;
          n_d     = '0;
          e_d     = '0;
          state_d = FWD;
        end
      end
      FWD: begin
        if (!bus.in_psel) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end else if (bus.in_penable) begin
          acc_d = acc_inc;
          n_d   = n_inc;
          if (bus.out_pready) begin
            rdata_d = bus.out_prdata;
            err_d   = bus.out_pslverr;
            e_d     = e_new;
            state_d = (e_new != '0) ? WAIT : RESP;
          end
        end
      end
      WAIT: begin
        if (!bus.in_psel) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end else begin
          e_d = e_q - CNT_W'(1);
          if (e_q <= CNT_W'(1)) state_d = RESP;
        end
      end
      RESP: begin
        if (!bus.in_psel) begin
          rdata_d = '0;
          err_d   = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.out_psel    = 1'b0;
    bus.out_penable = 1'b0;
    bus.in_pready   = 1'b0;
    bus.in_prdata   = rdata_q;
    bus.in_pslverr  = err_q;
    case (cur_state)
      IDLE: begin
        if (bus.in_psel && hit) begin
          bus.out_psel = 1'b1;
        end else begin
          bus.out_psel    = bus.in_psel;
          bus.out_penable = bus.in_penable;
          bus.in_pready   = bus.out_pready;
          bus.in_prdata   = bus.out_prdata;
          bus.in_pslverr  = bus.out_pslverr;
        end
      end
      FWD: begin
        bus.out_psel    = bus.in_psel;
        bus.out_penable = bus.in_penable;
      end
      RESP: bus.in_pready = bus.in_psel;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ratio_q <= '0;
      acc_q   <= '0;
      n_q     <= '0;
      e_q     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ratio_q <= ratio_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      e_q     <= e_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_apb_delayer_param.sv
// Randomized scoreboard bench for apb_delayer_param: the driver queues the expected
// upstream response per access and an independent monitor checks each completion.
module tb_apb_delayer_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ratio = '0;

  apb_delayer_param_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_delayer_param #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .WIN_BASE (32'ha000_0000),
    .WIN_LIMIT(32'hc000_0000),
    .FRAC     (4),
    .CNT_W    (16)
  ) dut (
    .clock(clk),
    .reset(rst),
    .ratio(ratio),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    bit          hit;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   cyc = 0;
  int   dn_cyc = 0;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Reference: extra waits = floor(ratio * N / 16) - N, never negative.
  function automatic int exp_e(int r, int n);
    int p;
    p = (r * n) / 16;
    return (p > n) ? (p - n) : 0;
  endfunction

  function automatic bit in_window(logic [31:0] a);
    return (a >= 32'ha000_0000) && (a < 32'hc000_0000);
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (bus.in_psel)
          chk("passthru", {bus.out_paddr, bus.out_pprot, bus.out_pwrite, bus.out_pwdata, bus.out_pstrb},
                          {bus.in_paddr, bus.in_pprot, bus.in_pwrite, bus.in_pwdata, bus.in_pstrb});
        if (bus.out_psel && bus.out_penable && bus.out_pready) dn_cyc = cyc;
        if (bus.in_psel && bus.in_penable && bus.in_pready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pready", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("prdata", bus.in_prdata, e.data);
            chk("pslverr", bus.in_pslverr, e.err);
            chk("latency", cyc - dn_cyc, e.lat);
            if (e.hit) chk("out_psel_in_resp", bus.out_psel, 0);
          end
        end
      end
    end
  end

  task automatic setup(input logic [31:0] addr, input bit wr, input int r);
    @(posedge clk); #1;
    bus.in_psel     = 1'b1;
    bus.in_penable  = 1'b0;
    bus.in_paddr    = addr;
    bus.in_pwrite   = wr;
    bus.in_pwdata   = $urandom;
    bus.in_pstrb    = 4'($urandom);
    bus.in_pprot    = 3'($urandom);
    ratio           = 8'(r);
    bus.out_pready  = 1'b0;
    bus.out_prdata  = $urandom;
    bus.out_pslverr = 1'b0;
  endtask

  task automatic idle_bus();
    @(posedge clk); #1;
    bus.in_psel    = 1'b0;
    bus.in_penable = 1'b0;
    bus.out_pready = 1'b0;
  endtask

  task automatic do_txn(input logic [31:0] addr, input bit wr, input int r, input int w,
                        input logic [31:0] rd, input bit err, input bit move_addr, input bit b2b);
    exp_t e;
    int   k;
    bit   done;
    e.hit  = in_window(addr);
    e.data = rd;
    e.err  = err;
    e.lat  = e.hit ? 1 + exp_e(r, w + 1) : 0;
    exp_q.push_back(e);
    setup(addr, wr, r);
    @(posedge clk); #1;
    bus.in_penable  = 1'b1;
    ratio           = (r == 80) ? 8'd16 : 8'($urandom);
    k               = 0;
    bus.out_pready  = (w == 0);
    bus.out_prdata  = (w == 0) ? rd : $urandom;
    bus.out_pslverr = (w == 0) ? err : 1'b0;
    done = 0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (bus.in_pready) begin
        done = 1;
      end else begin
        @(posedge clk); #1;
        k++;
        bus.out_pready  = (k == w);
        bus.out_prdata  = (k == w) ? rd : $urandom;
        bus.out_pslverr = (k == w) ? err : 1'b0;
        if (move_addr && k == 1) bus.in_paddr = 32'h3000_0000;
      end
    end
    if (!done) begin
      chk("pready_timeout", 0, 1);
      exp_q.delete();
    end
    if (!b2b) idle_bus();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    bus.in_psel     = 1'b0;
    bus.in_penable  = 1'b0;
    bus.in_paddr    = '0;
    bus.in_pprot    = '0;
    bus.in_pwrite   = 1'b0;
    bus.in_pwdata   = '0;
    bus.in_pstrb    = '0;
    bus.out_pready  = 1'b1;
    bus.out_prdata  = 32'hdead_beef;
    bus.out_pslverr = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pready_passthru", bus.in_pready, 1);
    chk("reset_prdata_passthru", bus.in_prdata, 32'hdead_beef);
    chk("reset_out_psel", bus.out_psel, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_pready = 1'b0;

    do_txn(32'ha000_0100, 0, 80, 1, 32'h1234_5678, 0, 0, 0);
    do_txn(32'ha000_0200, 1, 16, 0, 32'h0bad_cafe, 0, 0, 0);
    do_txn(32'h3000_0000, 0, 80, 2, 32'h5555_aaaa, 0, 0, 0);
    do_txn(32'hb000_0000, 0, 24, 2, 32'h0000_0024, 1, 0, 0);
    do_txn(32'ha000_0000, 0,  0, 3, 32'h0000_0000, 0, 0, 1);
    do_txn(32'hbfff_fffc, 1, 255, 4, 32'hffff_0000, 0, 1, 0);

    // Reset while waiting with five extra cycles still to go.
    setup(32'ha000_0010, 0, 80);
    @(posedge clk); #1;
    bus.in_penable = 1'b1;
    @(posedge clk); #1;
    bus.out_pready = 1'b1;
    bus.out_prdata = 32'h7777_7777;
    @(posedge clk); #1;
    bus.out_pready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_no_pready", bus.in_pready, 0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_no_pready", bus.in_pready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_psel    = 1'b0;
    bus.in_penable = 1'b0;
    bus.out_pready = 1'b1;
    @(negedge clk);
    chk("post_reset_idle_pready", bus.in_pready, 1);
    chk("post_reset_out_psel", bus.out_psel, 0);
    idle_bus();
    do_txn(32'ha000_0020, 0, 80, 1, 32'h1357_9bdf, 0, 0, 0);

    // Master drops psel while the bridge is waiting.
    setup(32'ha000_0030, 0, 80);
    @(posedge clk); #1;
    bus.in_penable = 1'b1;
    bus.out_pready = 1'b1;
    @(posedge clk); #1;
    bus.in_psel    = 1'b0;
    bus.in_penable = 1'b0;
    bus.out_pready = 1'b0;
    @(negedge clk);
    chk("abort_no_pready", bus.in_pready, 0);
    chk("abort_out_psel", bus.out_psel, 0);
    @(posedge clk); #1;
    bus.out_pready = 1'b1;
    @(negedge clk);
    chk("abort_back_to_idle", bus.in_pready, 1);
    idle_bus();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: a = 32'ha000_0000;
        1: a = 32'hbfff_ffff;
        2: a = 32'hc000_0000;
        3: a = 32'h9fff_ffff;
        4: a = 32'ha000_0000 + ($urandom & 32'h1fff_ffff);
        default: a = $urandom;
      endcase
      do_txn(a, 1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 4)), $urandom,
             1'($urandom), in_window(a) && ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end
    idle_bus();

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
